// File: rtl/sys_sum_pkg.sv
// rtl/sys_sum_pkg.sv - shared word type and adder for sys_sum
// Macro SYS_SUM_SATURATE_EN selects saturating instead of wrapping additions.
package sys_sum_pkg;

  localparam int BIT_SIZE = 4;

  typedef logic [BIT_SIZE-1:0] word_t;

  // Operands and result are zero-extended to 32 bits; callers cast back to their width (w < 32).
  function automatic logic [31:0] add_w(input logic [31:0] a, input logic [31:0] b,
                                        input int unsigned w);
    logic [31:0] sum;
`ifdef SYS_SUM_SATURATE_EN
    logic [31:0] lim;
    lim = (32'd1 << w) - 32'd1;
    sum = a + b;
    if (sum > lim) sum = lim;
`else
    sum = a + b;
`endif
    return sum;
  endfunction

endpackage

// File: rtl/sys_sum_pe.sv
// rtl/sys_sum_pe.sv - one systolic chain stage: data, valid and start registers with gated add
// Addition behaviour follows SYS_SUM_SATURATE_EN through sys_sum_pkg::add_w.
module sys_sum_pe
  import sys_sum_pkg::*;
#(
  parameter int BitSize = 4,
  parameter bit First   = 1'b0
) (
  input  logic               clk,
  input  logic               res_n,
  input  logic [BitSize-1:0] prev_sum,
  input  logic               prev_valid,
  input  logic               prev_start,
  input  logic [BitSize-1:0] lane,
  output logic [BitSize-1:0] sum,
  output logic               valid,
  output logic               start
);

  logic [BitSize-1:0] sum_nx;
  logic               start_nx;

  // The head stage takes lane 0 directly; later stages add their lane only behind a valid beat.
  always_comb begin
    sum_nx   = '0;
    start_nx = 1'b0;
    if (First) begin
      sum_nx   = lane;
      start_nx = prev_start & prev_valid;
    end else begin
      sum_nx   = BitSize'(add_w(32'(prev_sum), prev_valid ? 32'(lane) : 32'd0, BitSize));
      start_nx = prev_start;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sum   <= '0;
      valid <= 1'b0;
      start <= 1'b0;
    end else begin
      sum   <= sum_nx;
      valid <= prev_valid;
      start <= start_nx;
    end
  end

endmodule

// File: rtl/sys_sum.sv
// rtl/sys_sum.sv - systolic column adder with per-group beat accumulation
// Macro SYS_SUM_SATURATE_EN selects saturating instead of wrapping additions.
module sys_sum
  import sys_sum_pkg::*;
#(
  parameter int BitSize     = BIT_SIZE,
  parameter int NumOfNerves = 2,
  parameter int DepthIn     = 2
) (
  input  logic                                  clk,
  input  logic                                  res_n,
  input  logic                                  in_valid,
  input  logic                                  in_start,
  input  logic [NumOfNerves-1:0][BitSize-1:0]   in_data,
  output logic                                  out_valid,
  output logic                                  out_start,
  output logic [BitSize-1:0]                    out_data
);

  localparam int CntW = $clog2(DepthIn + 1);

  logic [BitSize-1:0] s  [NumOfNerves];
  logic               v  [NumOfNerves];
  logic               st [NumOfNerves];

  for (genvar k = 0; k < NumOfNerves; k++) begin : g_stage
    if (k == 0) begin : g_head
      sys_sum_pe #(.BitSize(BitSize), .First(1'b1)) u_pe (
        .clk        (clk),
        .res_n      (res_n),
        .prev_sum   ('0),
        .prev_valid (in_valid),
        .prev_start (in_start),
        .lane       (in_data[0]),
        .sum        (s[0]),
        .valid      (v[0]),
        .start      (st[0])
      );
    end else begin : g_body
      sys_sum_pe #(.BitSize(BitSize), .First(1'b0)) u_pe (
        .clk        (clk),
        .res_n      (res_n),
        .prev_sum   (s[k-1]),
        .prev_valid (v[k-1]),
        .prev_start (st[k-1]),
        .lane       (in_data[k]),
        .sum        (s[k]),
        .valid      (v[k]),
        .start      (st[k])
      );
    end
  end

  logic [BitSize-1:0] tail_sum;
  logic               tail_valid;
  logic               tail_start;

  assign tail_sum   = s[NumOfNerves-1];
  assign tail_valid = v[NumOfNerves-1];
  assign tail_start = st[NumOfNerves-1];

  logic [BitSize-1:0] acc, acc_nx;
  logic [CntW-1:0]    cnt, cnt_nx;
  logic               first, first_nx;
  logic               done;

  // A start beat reopens the group, dropping whatever partial sum was pending.
  always_comb begin
    acc_nx   = acc;
    cnt_nx   = cnt;
    first_nx = first;
    done     = 1'b0;
    if (tail_valid) begin
      if (tail_start) begin
        acc_nx   = tail_sum;
        cnt_nx   = CntW'(1);
        first_nx = 1'b1;
      end else begin
        acc_nx = BitSize'(add_w(32'(acc), 32'(tail_sum), BitSize));
        cnt_nx = cnt + CntW'(1);
      end
      done = (cnt_nx == CntW'(DepthIn));
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      acc       <= '0;
      cnt       <= '0;
      first     <= 1'b0;
      out_valid <= 1'b0;
      out_start <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= done;
      out_start <= done & first_nx;
      if (done) begin
        out_data <= acc_nx;
        acc      <= '0;
        cnt      <= '0;
        first    <= 1'b0;
      end else begin
        acc   <= acc_nx;
        cnt   <= cnt_nx;
        first <= first_nx;
      end
    end
  end

endmodule

// File: tb/tb_sys_sum.sv
// tb/tb_sys_sum.sv - directed self-checking bench for sys_sum (BitSize=4, N=2, DepthIn=2)
// Expected wrap/saturate results follow SYS_SUM_SATURATE_EN.
module tb_sys_sum;

  logic            clk;
  logic            res_n;
  logic            in_valid;
  logic            in_start;
  logic [1:0][3:0] in_data;
  logic            out_valid;
  logic            out_start;
  logic [3:0]      out_data;

  int         tests;
  int         fails;
  logic [3:0] lane1_q;

  sys_sum #(.BitSize(4), .NumOfNerves(2), .DepthIn(2)) dut (
    .clk       (clk),
    .res_n     (res_n),
    .in_valid  (in_valid),
    .in_start  (in_start),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_start (out_start),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic ov, input logic os, input logic [3:0] od);
    check({tag, ".valid"}, 32'(out_valid), 32'(ov));
    if (ov) begin
      check({tag, ".start"}, 32'(out_start), 32'(os));
      check({tag, ".data"}, 32'(out_data), 32'(od));
    end
  endtask

  // Lane 1 of a beat is delivered one cycle after its lane 0.
  task automatic step(input logic v, input logic s, input logic [3:0] l0, input logic [3:0] l1);
    in_valid   = v;
    in_start   = s;
    in_data[0] = l0;
    in_data[1] = lane1_q;
    lane1_q    = l1;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] wrap_exp;

  initial begin
    tests    = 0;
    fails    = 0;
    lane1_q  = '0;
    res_n    = 1'b0;
    in_valid = 1'b0;
    in_start = 1'b0;
    in_data  = '0;
`ifdef SYS_SUM_SATURATE_EN
    wrap_exp = 4'd15;
`else
    wrap_exp = 4'd0;
`endif

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("rst.valid", 32'(out_valid), 0);
    check("rst.start", 32'(out_start), 0);
    check("rst.data", 32'(out_data), 0);
    res_n = 1'b1;

    // Skewed stream, starts on beats 0 and 2: sums 0,4 | 3,0
    step(1, 1, 0, 0);
    step(1, 0, 3, 1);
    step(1, 1, 3, 0);
    check_out("t1.early", 0, 0, 0);
    step(1, 0, 0, 0);
    check_out("t1.out0", 1, 1, 4);
    step(0, 0, 0, 0);
    check_out("t1.pulse0", 0, 0, 0);
    step(0, 0, 0, 0);
    check_out("t1.out1", 1, 1, 3);
    step(0, 0, 0, 0);
    check_out("t1.pulse1", 0, 0, 0);

    // One start, beat sums 1,2,3,4
    step(1, 1, 1, 0);
    step(1, 0, 1, 1);
    step(1, 0, 2, 1);
    step(1, 0, 0, 4);
    check_out("t2.out0", 1, 1, 3);
    step(0, 0, 0, 0);
    check_out("t2.gap", 0, 0, 0);
    step(0, 0, 0, 0);
    check_out("t2.out1", 1, 0, 7);

    // Gap: 5, idle (lanes and start ignored), 6
    step(1, 0, 2, 3);
    step(0, 1, 9, 7);
    step(1, 0, 4, 2);
    check_out("t3.early", 0, 0, 0);
    step(0, 0, 0, 0);
    check_out("t3.early2", 0, 0, 0);
    step(0, 0, 0, 0);
    check_out("t3.out", 1, 0, 11);

    // Overflow in chain (15+15) and accumulator (+2)
    step(1, 1, 15, 15);
    step(1, 0, 2, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_out("t4.wrap", 1, 1, wrap_exp);

    // Restart drops the partial group
    step(1, 1, 2, 0);
    step(1, 1, 1, 0);
    step(1, 0, 0, 1);
    check_out("t5.none0", 0, 0, 0);
    step(0, 0, 0, 0);
    check_out("t5.none1", 0, 0, 0);
    step(0, 0, 0, 0);
    check_out("t5.out", 1, 1, 2);

    // Reset mid-group clears outputs immediately
    step(1, 1, 7, 0);
    step(1, 0, 3, 1);
    res_n = 1'b0;
    #2;
    check("t6.rst.valid", 32'(out_valid), 0);
    check("t6.rst.start", 32'(out_start), 0);
    check("t6.rst.data", 32'(out_data), 0);
    lane1_q = '0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("t6.hold.valid", 32'(out_valid), 0);
    check("t6.hold.data", 32'(out_data), 0);
    res_n = 1'b1;

    // Fresh group after reset, no start: 2 + 2
    step(1, 0, 1, 1);
    step(1, 0, 2, 0);
    check_out("t6.early", 0, 0, 0);
    step(0, 0, 0, 0);
    check_out("t6.early2", 0, 0, 0);
    step(0, 0, 0, 0);
    check_out("t6.out", 1, 0, 4);
    step(0, 0, 0, 0);
    check_out("t6.pulse", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
